// File: rtl/vram_arbiter.sv
// Arbitrates one single-port video SRAM between scanout reads and a host port.
// Scanout has priority; host anti-starvation; bus turnaround on direction change.
module vram_arbiter #(
  parameter int ADDR_W        = 18,
  parameter int DATA_W        = 16,
  parameter int RD_LAT        = 2,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              vid_urgent,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

  // State records the bus direction issued by the previous cycle's grant.
  typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              host_wins;
  logic              win_we;
  logic              gnt_ok;
  logic [RD_LAT:0]   pipe_valid;
  logic [RD_LAT:0]   pipe_host;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    host_wins  = host_req && (!vid_req || ((wait_cnt >= WAIT_MAX) && !vid_urgent));
    win_we     = host_wins && host_we;
    gnt_ok     = 1'b0;
    state_next = IDLE;
    if (!rst && (vid_req || host_req)) begin
      case (state)
        IDLE:    gnt_ok = 1'b1;
        RD:      gnt_ok = !win_we;
        WR:      gnt_ok = win_we;
        default: gnt_ok = 1'b0;
      endcase
      if (state != TURN) begin
        state_next = gnt_ok ? (win_we ? WR : RD) : TURN;
      end
    end
    vid_gnt  = gnt_ok && !host_wins;
    host_gnt = gnt_ok && host_wins;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
      pipe_valid  <= '0;
      pipe_host   <= '0;
      vid_rvalid  <= 1'b0;
      vid_rdata   <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state <= state_next;

      if (host_gnt) begin
        wait_cnt <= '0;
      end else if (host_req && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      mem_oe <= gnt_ok && !win_we;
      mem_we <= gnt_ok && win_we;
      if (gnt_ok) begin
        mem_addr <= host_wins ? host_addr : vid_addr;
      end
      if (gnt_ok && win_we) begin
        mem_wdata <= host_wdata;
      end

      // Stage k is valid during grant+1+k; the last stage lines up with mem_rdata.
      pipe_valid <= {pipe_valid[RD_LAT-1:0], gnt_ok && !win_we};
      pipe_host  <= {pipe_host[RD_LAT-1:0], host_wins};

      vid_rvalid  <= pipe_valid[RD_LAT] && !pipe_host[RD_LAT];
      host_rvalid <= pipe_valid[RD_LAT] && pipe_host[RD_LAT];
      if (pipe_valid[RD_LAT] && !pipe_host[RD_LAT]) begin
        vid_rdata <= mem_rdata;
      end
      if (pipe_valid[RD_LAT] && pipe_host[RD_LAT]) begin
        host_rdata <= mem_rdata;
      end
    end
  end

endmodule
